// File: rtl/sparse_term_scheduler.sv
// Issues a fixed number of term slots per multiplication, padding with dummy
// slots so the schedule length never depends on the sparse word count.
module sparse_term_scheduler #(
   parameter int unsigned SLOTS      = 64,
   parameter logic [9:0]  DUMMY_ADDR = 10'd1023,
   parameter int unsigned WAIT_MAX   = 4095
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] real_count,
   output logic       ctrl_start,
   output logic [9:0] ctrl_sparse_addr,
   output logic       ctrl_dummy,
   input  logic       ctrl_done,
   output logic [6:0] slot_idx,
   output logic       busy,
   output logic       done,
   output logic [1:0] err
);

   localparam int unsigned WW = $clog2(WAIT_MAX + 1);
   localparam logic [7:0] SLOTS_C = 8'(SLOTS);
   localparam logic [6:0] LAST_SLOT = 7'(SLOTS - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

   typedef enum logic [2:0] {
      IDLE, CHECK, ISSUE, WAIT, NEXT, FINISH
   } state_e;

   state_e        state_q, state_d;
   logic [6:0]    cnt_q, cnt_d;
   logic [6:0]    slot_q, slot_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [1:0]    err_q, err_d;
   logic          real_slot;
   logic          slot_live;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         slot_q  <= '0;
         wait_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         wait_q  <= wait_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      slot_d  = slot_q;
      wait_d  = wait_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            // done_q high means this is the completion cycle; a start here is dropped
            if (start && !done_q) begin
               cnt_d   = real_count;
               err_d   = 2'd0;
               slot_d  = '0;
               busy_d  = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if ({1'b0, cnt_q} > SLOTS_C) begin
               err_d   = 2'd1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wait_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (ctrl_done) begin
               state_d = NEXT;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 2'd2;
               state_d = FINISH;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         NEXT: begin
            if (slot_q == LAST_SLOT) begin
               state_d = FINISH;
            end else begin
               slot_d  = slot_q + 1'b1;
               state_d = ISSUE;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Real/dummy only steers the address mux, never the control flow
   assign real_slot = slot_q < cnt_q;
   assign slot_live = (state_q == ISSUE) || (state_q == WAIT);

   assign ctrl_start       = state_q == ISSUE;
   assign ctrl_dummy       = slot_live && !real_slot;
   assign ctrl_sparse_addr = !slot_live ? 10'd0 :
                             real_slot  ? {3'b000, slot_q} : DUMMY_ADDR;
   assign slot_idx         = slot_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;

endmodule

// File: tb/tb_sparse_term_scheduler.sv
// Directed bench for sparse_term_scheduler with a fixed-latency controller model.
module tb_sparse_term_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [6:0] real_count;
   logic       ctrl_start;
   logic [9:0] ctrl_sparse_addr;
   logic       ctrl_dummy;
   logic       ctrl_done;
   logic [6:0] slot_idx;
   logic       busy;
   logic       done;
   logic [1:0] err;

   sparse_term_scheduler #(
      .SLOTS(64), .DUMMY_ADDR(10'd1023), .WAIT_MAX(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .real_count(real_count),
      .ctrl_start(ctrl_start), .ctrl_sparse_addr(ctrl_sparse_addr),
      .ctrl_dummy(ctrl_dummy), .ctrl_done(ctrl_done), .slot_idx(slot_idx),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   nchecks = 0;
   int   nerr = 0;
   int   n_starts = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   cd = 0;
   logic model_done = 1'b0;
   logic stray_done = 1'b0;
   logic ctl_en = 1'b1;
   logic [9:0] addr_log [64];
   logic       dum_log [64];

   assign ctrl_done = model_done | stray_done;

   always @(posedge clk) cyc++;

   // Controller model: ctrl_done 5 cycles after each ctrl_start; monitor
   always @(posedge clk) begin
      #1;
      if (ctrl_start) begin
         if (n_starts < 64) begin
            addr_log[n_starts] = ctrl_sparse_addr;
            dum_log[n_starts]  = ctrl_dummy;
         end
         n_starts++;
         cd = 5;
         model_done = 1'b0;
      end else if (cd > 0) begin
         cd--;
         model_done = ctl_en && (cd == 0);
      end else begin
         model_done = 1'b0;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_log(input int rc);
      int bad;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         if (i < rc) begin
            if (addr_log[i] !== 10'(i) || dum_log[i] !== 1'b0) bad++;
         end else begin
            if (addr_log[i] !== 10'd1023 || dum_log[i] !== 1'b1) bad++;
         end
      end
      chk("slot_map_errors", bad, 0);
   endtask

   task automatic run(input logic [6:0] rc, input int hold, input bit stray,
                      output int lat);
      int s0;
      int b;
      n_starts = 0;
      done_cnt = 0;
      done_cyc = 0;
      @(negedge clk);
      s0 = cyc;
      real_count = rc;
      start = 1'b1;
      for (int k = 1; k <= hold; k++) begin
         @(negedge clk);
         stray_done = stray && (k == 2);
         if (k == 1) chk("busy_after_start", busy, 1);
      end
      start = 1'b0;
      stray_done = 1'b0;
      b = 0;
      while (done_cnt == 0 && b < 600) begin
         @(negedge clk);
         b++;
      end
      lat = (done_cnt != 0) ? done_cyc - s0 : -1;
      repeat (4) @(negedge clk);
   endtask

   int lat_a, lat_b, lat_c;
   int b;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      real_count = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs",
          {ctrl_start, ctrl_dummy, ctrl_sparse_addr, slot_idx, busy, done, err}, 0);
      rst = 1'b0;

      run(7'd50, 1, 1'b0, lat_a);
      chk("rc50_latency", lat_a, 451);
      chk("rc50_ctrl_starts", n_starts, 64);
      chk_log(50);
      chk("rc50_done_pulses", done_cnt, 1);
      chk("rc50_err", err, 0);
      chk("rc50_busy_after", busy, 0);
      chk("rc50_slot_last", slot_idx, 63);

      run(7'd10, 1, 1'b0, lat_b);
      chk("rc10_latency", lat_b, 451);
      chk_log(10);
      run(7'd60, 1, 1'b0, lat_c);
      chk("rc60_latency", lat_c, 451);
      chk("rc10_rc60_equal", lat_b, lat_c);
      chk_log(60);

      run(7'd70, 1, 1'b0, lat_a);
      chk("rc70_latency", lat_a, 2);
      chk("rc70_err", err, 1);
      chk("rc70_ctrl_starts", n_starts, 0);
      chk("rc70_done_pulses", done_cnt, 1);

      run(7'd0, 1, 1'b0, lat_a);
      chk("rc0_latency", lat_a, 451);
      chk_log(0);

      ctl_en = 1'b0;
      run(7'd3, 1, 1'b0, lat_a);
      chk("timeout_latency", lat_a, 20);
      chk("timeout_err", err, 2);
      chk("timeout_slot", slot_idx, 0);
      chk("timeout_done_pulses", done_cnt, 1);
      chk("timeout_busy", busy, 0);
      chk("timeout_ctrl_starts", n_starts, 1);
      ctl_en = 1'b1;

      run(7'd64, 3, 1'b1, lat_a);
      chk("held_latency", lat_a, 451);
      chk("held_ctrl_starts", n_starts, 64);
      chk("held_done_pulses", done_cnt, 1);
      chk("held_err_cleared", err, 0);
      chk("held_busy_after", busy, 0);
      chk_log(64);

      n_starts = 0;
      done_cnt = 0;
      @(negedge clk);
      real_count = 7'd64;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      b = 0;
      while (!done && b < 600) begin
         @(negedge clk);
         b++;
      end
      chk("done_seen", done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_on_done_ignored", busy, 0);
      repeat (5) @(negedge clk);
      chk("start_on_done_no_issue", n_starts, 64);

      n_starts = 0;
      done_cnt = 0;
      @(negedge clk);
      real_count = 7'd64;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      b = 0;
      while (n_starts < 21 && b < 600) begin
         @(negedge clk);
         b++;
      end
      chk("slot_before_rst", slot_idx, 20);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_reset_outputs",
          {ctrl_start, ctrl_dummy, ctrl_sparse_addr, slot_idx, busy, done, err}, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("no_done_after_rst", done_cnt, 0);
      chk("idle_after_rst", busy, 0);

      run(7'd5, 1, 1'b0, lat_a);
      chk("post_rst_latency", lat_a, 451);
      chk("post_rst_ctrl_starts", n_starts, 64);
      chk_log(5);
      chk("post_rst_err", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
